// File: rtl/ibuf_offset_cal.sv
// Offset-trim calibration controller for a differential input buffer.
// It sweeps the trim code from -7 to +7 and keeps the first code at which the shorted-input output reads 1.
module ibuf_offset_cal #(
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_COUNT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       buf_o,
    output logic [3:0] osc,
    output logic [1:0] osc_en,
    output logic       busy,
    output logic       done,
    output logic       cal_ok,
    output logic [3:0] cal_code
);

    localparam int ONES_W  = $clog2(SAMPLE_COUNT + 1);
    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DECIDE} state_t;

    state_t              state, state_n;
    logic [3:0]          k, k_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [ONES_W-1:0]   ones, ones_n;
    logic [3:0]          osc_n, cal_code_n;
    logic                en, en_n;
    logic                busy_n, done_n, cal_ok_n;
    logic                o_p0, o_p1, o_s;
    logic                r;

    // Sweep index k maps to signed trim v = k-7 in sign-magnitude form.
    function automatic logic [3:0] trim_code(input logic [3:0] idx);
        if (idx >= 4'd7)
            trim_code = {1'b1, 3'(idx - 4'd7)};
        else
            trim_code = {1'b0, 3'(4'd7 - idx)};
    endfunction

    // Stage p0/p1: free-running synchronizer, deliberately outside reset.
    always_ff @(posedge clk) begin
        o_p0 <= buf_o;
        o_p1 <= o_p0;
    end
    assign o_s = o_p1;

    // A tie in the majority vote counts as 0.
    assign r = ({1'b0, ones, 1'b0} > (ONES_W + 2)'(SAMPLE_COUNT));

    // One enable register drives both osc_en bits so they can never disagree.
    assign osc_en = {2{en}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            cnt      <= '0;
            ones     <= '0;
            osc      <= 4'b0000;
            en       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cal_ok   <= 1'b0;
            cal_code <= 4'b0000;
        end else begin
            state    <= state_n;
            k        <= k_n;
            cnt      <= cnt_n;
            ones     <= ones_n;
            osc      <= osc_n;
            en       <= en_n;
            busy     <= busy_n;
            done     <= done_n;
            cal_ok   <= cal_ok_n;
            cal_code <= cal_code_n;
        end
    end

    always_comb begin
        state_n    = state;
        k_n        = k;
        cnt_n      = cnt;
        ones_n     = ones;
        osc_n      = osc;
        en_n       = en;
        busy_n     = busy;
        done_n     = 1'b0;
        cal_ok_n   = cal_ok;
        cal_code_n = cal_code;
        case (state)
            IDLE: begin
                if (start) begin
                    k_n     = 4'd0;
                    cnt_n   = '0;
                    ones_n  = '0;
                    osc_n   = trim_code(4'd0);
                    en_n    = 1'b1;
                    busy_n  = 1'b1;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SAMPLE: begin
                ones_n = ones + ONES_W'(o_s);
                if (cnt == CNT_W'(SAMPLE_COUNT - 1)) begin
                    cnt_n   = '0;
                    state_n = DECIDE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DECIDE: begin
                if (r || k == 4'd14) begin
                    en_n     = 1'b0;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                    cal_ok_n = r && (k != 4'd0);
                    if (r && k != 4'd0) begin
                        cal_code_n = trim_code(k);
                        osc_n      = trim_code(k);
                    end else begin
                        cal_code_n = 4'b1000;
                        osc_n      = 4'b1000;
                    end
                end else begin
                    k_n     = k + 1'b1;
                    osc_n   = trim_code(k + 1'b1);
                    ones_n  = '0;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
